// File: rtl/serial_frame_decoder_if.sv
// Byte stream in from the serial receiver, payload stream out to downstream.
//
// Handshake semantics:
//   Input side:  byte_ready and timeout are levels; only their rising edges
//   count. byte_in must be stable from the rising edge of byte_ready until
//   byte_ready falls.
//   Output side: out_valid/out_ready. A byte transfers on every rising clock
//   edge where out_valid && out_ready. Once out_valid is high, out_data and
//   out_last stay stable until that transfer. out_ready may be driven freely;
//   it is not allowed to depend on anything other than the downstream state.
interface serial_frame_decoder_if;
    logic [7:0] byte_in;
    logic       byte_ready;
    logic       timeout;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    // Receiver/downstream side (testbench or surrounding logic)
    modport master (
        output byte_in, byte_ready, timeout, out_ready,
        input  out_data, out_valid, out_last
    );

    // Decoder side
    modport slave (
        input  byte_in, byte_ready, timeout, out_ready,
        output out_data, out_valid, out_last
    );
endinterface

// File: rtl/serial_frame_decoder.sv
// Serial frame decoder: hunts for HEADER, reads LEN, buffers LEN payload
// bytes, verifies CHK = (LEN + sum(payload)) mod 256, then drains the buffer
// over a valid/ready stream. Status and error outcomes are one-cycle
// registered pulses; err_cnt saturates at 8'hFF.
module serial_frame_decoder #(
    parameter logic [7:0] HEADER  = 8'hA5,
    parameter int         MAX_LEN = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_frame_decoder_if.slave  bus,
    output logic                   frame_ok,
    output logic                   err_len,
    output logic                   err_chk,
    output logic                   err_timeout,
    output logic                   err_overrun,
    output logic [7:0]             err_cnt,
    // Debug view of the FSM: 0=HUNT 1=LEN 2=PAYLOAD 3=CHK 4=DRAIN
    output logic [2:0]             state_dbg
);

    // Index width covers 0..MAX_LEN-1; keep at least one bit for MAX_LEN=1.
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [IDX_W-1:0] IDX_ONE   = 1;

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHK     = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             byte_prev_q, byte_prev_d;
    logic             tmo_prev_q, tmo_prev_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       sum_q, sum_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic             frame_ok_q, frame_ok_d;
    logic             err_len_q, err_len_d;
    logic             err_chk_q, err_chk_d;
    logic             err_tmo_q, err_tmo_d;
    logic             err_ovr_q, err_ovr_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    // Payload buffer; contents are don't-care after reset.
    logic [7:0]       frame_buf [MAX_LEN];
    logic             buf_we;

    logic             byte_stb;
    logic             tmo_stb;
    logic [7:0]       len_last;
    logic             in_drain;
    logic             any_err_q;

    assign byte_stb  = bus.byte_ready & ~byte_prev_q;
    assign tmo_stb   = bus.timeout & ~tmo_prev_q;
    assign len_last  = len_q - 8'd1;
    assign in_drain  = (state_q == S_DRAIN);
    assign any_err_q = err_len_q | err_chk_q | err_tmo_q | err_ovr_q;

    // Next-state, datapath updates and registered-pulse requests
    always_comb begin
        state_d     = state_q;
        byte_prev_d = bus.byte_ready;
        tmo_prev_d  = bus.timeout;
        len_d       = len_q;
        sum_d       = sum_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        frame_ok_d  = 1'b0;
        err_len_d   = 1'b0;
        err_chk_d   = 1'b0;
        err_tmo_d   = 1'b0;
        err_ovr_d   = 1'b0;
        buf_we      = 1'b0;

        // One increment per cycle with any error pulse showing.
        err_cnt_d = err_cnt_q;
        if (any_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        case (state_q)
            S_HUNT: begin
                // A simultaneous timeout discards the byte even here.
                if (byte_stb && !tmo_stb && (bus.byte_in == HEADER)) begin
                    state_d = S_LEN;
                end
            end

            S_LEN: begin
                if (tmo_stb) begin
                    err_tmo_d = 1'b1;
                    state_d   = S_HUNT;
                end else if (byte_stb) begin
                    if ((bus.byte_in >= 8'd1) && (bus.byte_in <= MAX_LEN_B)) begin
                        len_d    = bus.byte_in;
                        sum_d    = bus.byte_in;
                        wr_idx_d = '0;
                        state_d  = S_PAYLOAD;
                    end else begin
                        err_len_d = 1'b1;
                        state_d   = S_HUNT;
                    end
                end
            end

            S_PAYLOAD: begin
                if (tmo_stb) begin
                    err_tmo_d = 1'b1;
                    state_d   = S_HUNT;
                end else if (byte_stb) begin
                    buf_we   = 1'b1;
                    sum_d    = sum_q + bus.byte_in;
                    wr_idx_d = wr_idx_q + IDX_ONE;
                    if (8'(wr_idx_q) == len_last) begin
                        state_d = S_CHK;
                    end
                end
            end

            S_CHK: begin
                if (tmo_stb) begin
                    err_tmo_d = 1'b1;
                    state_d   = S_HUNT;
                end else if (byte_stb) begin
                    if (bus.byte_in == sum_q) begin
                        frame_ok_d = 1'b1;
                        rd_idx_d   = '0;
                        state_d    = S_DRAIN;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = S_HUNT;
                    end
                end
            end

            S_DRAIN: begin
                // Bytes arriving while the buffer is still draining are lost.
                if (byte_stb && !tmo_stb) begin
                    err_ovr_d = 1'b1;
                end
                if (bus.out_ready) begin
                    rd_idx_d = rd_idx_q + IDX_ONE;
                    if (8'(rd_idx_q) == len_last) begin
                        state_d = S_HUNT;
                    end
                end
            end

            default: begin
                state_d = S_HUNT;
            end
        endcase
    end

    // Control and status registers; edge detectors reset high so levels
    // already asserted at reset release are not seen as strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HUNT;
            byte_prev_q <= 1'b1;
            tmo_prev_q  <= 1'b1;
            len_q       <= 8'd0;
            sum_q       <= 8'd0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            frame_ok_q  <= 1'b0;
            err_len_q   <= 1'b0;
            err_chk_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            byte_prev_q <= byte_prev_d;
            tmo_prev_q  <= tmo_prev_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            frame_ok_q  <= frame_ok_d;
            err_len_q   <= err_len_d;
            err_chk_q   <= err_chk_d;
            err_tmo_q   <= err_tmo_d;
            err_ovr_q   <= err_ovr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Payload buffer write port (no reset needed)
    always_ff @(posedge clk) begin
        if (buf_we) begin
            frame_buf[wr_idx_q] <= bus.byte_in;
        end
    end

    // Output stream is a pure function of registered state, so it drops to
    // idle the moment reset asserts.
    assign bus.out_valid = in_drain;
    assign bus.out_data  = in_drain ? frame_buf[rd_idx_q] : 8'h00;
    assign bus.out_last  = in_drain && (8'(rd_idx_q) == len_last);

    assign frame_ok    = frame_ok_q;
    assign err_len     = err_len_q;
    assign err_chk     = err_chk_q;
    assign err_timeout = err_tmo_q;
    assign err_overrun = err_ovr_q;
    assign err_cnt     = err_cnt_q;
    assign state_dbg   = state_q;

endmodule

// File: doc/serial_frame_decoder.md
SERIAL_FRAME_DECODER -- requirements
Module: serial_frame_decoder

Interface
REQ-001 Parameter HEADER, default 8'hA5: frame start byte.
REQ-002 Parameter MAX_LEN, default 16: maximum payload length in bytes, range 1..255.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 byte_in  input  8  received byte from the serial receiver stage.
REQ-006 byte_ready  input  1  level; a new byte is valid from its rising edge onward.
REQ-007 timeout  input  1  level; a rising edge means line-idle timeout.
REQ-008 out_data  output  8  payload byte being presented.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 out_ready  input  1  downstream accepts out_data.
REQ-011 out_last  output  1  marks the final payload byte of a frame.
REQ-012 frame_ok  output  1  one-cycle pulse: frame passed checks.
REQ-013 err_len, err_chk, err_timeout, err_overrun  output  1 each  one-cycle error pulses.
REQ-014 err_cnt  output  8  saturating error count.

Function
REQ-015 Frame format SHALL be: HEADER, LEN, LEN payload bytes, CHK, where CHK = (LEN + sum of payload) mod 256.
REQ-016 Byte strobe SHALL be the rising edge of byte_ready: byte_ready=1 AND registered previous value=0. Timeout strobe SHALL be detected the same way from timeout.
REQ-017 The block SHALL sample byte_in in the cycle of the byte strobe.
REQ-018 States SHALL be HUNT, LEN, PAYLOAD, CHK and DRAIN.
REQ-019 HUNT: on a byte strobe with byte_in==HEADER, go to LEN. Any other byte SHALL be ignored silently.
REQ-020 LEN: on a byte strobe with 1<=byte_in<=MAX_LEN, store the length, set sum=byte_in, set wr_idx=0, and go to PAYLOAD.
REQ-021 LEN: on a byte strobe with any other value, pulse err_len and go to HUNT.
REQ-022 PAYLOAD: on each byte strobe, write buf[wr_idx]=byte_in, add byte_in to sum (8-bit, wraps), and increment wr_idx. After the byte with wr_idx==len-1, go to CHK.
REQ-023 CHK: on a byte strobe with byte_in==sum, pulse frame_ok, clear rd_idx, and go to DRAIN.
REQ-024 CHK: on a byte strobe with byte_in!=sum, pulse err_chk and go to HUNT.
REQ-025 Timeout strobe in LEN, PAYLOAD or CHK SHALL pulse err_timeout and force HUNT. In HUNT or DRAIN it SHALL be ignored.
REQ-026 If a byte strobe and a timeout strobe occur in the same cycle, the timeout SHALL win and the byte SHALL be discarded.
REQ-027 DRAIN: out_valid=1 and out_data=buf[rd_idx]. out_last=1 when rd_idx==len-1.
REQ-028 DRAIN: each cycle with out_valid AND out_ready SHALL increment rd_idx. Acceptance of the last byte SHALL return the block to HUNT in the next cycle, with out_valid=0.
REQ-029 out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-030 A byte strobe in DRAIN SHALL pulse err_overrun, drop the byte, and leave the block in DRAIN.
REQ-031 out_valid SHALL be 0 in every state other than DRAIN.
REQ-032 All pulses SHALL be registered: high exactly one cycle, in the cycle after the triggering strobe.
REQ-033 err_cnt SHALL increment by 1 on each cycle in which any err_* pulse is high, and SHALL saturate at 8'hFF.
REQ-034 Buffer SHALL be MAX_LEN x 8 bits. wr_idx and rd_idx SHALL be wide enough for MAX_LEN-1.

Reset
REQ-035 While rst_n=0, the following SHALL be cleared: state=HUNT; out_valid, out_last, frame_ok and all err_* pulses = 0; err_cnt=0; out_data=0; sum, len and both indices = 0.
REQ-036 Edge-detect previous-value registers SHALL reset to 1, so input levels already high at release do not produce strobes.
REQ-037 Reset asserted mid-frame or mid-DRAIN SHALL abandon the frame with no pulses. Buffer contents need not be cleared.

Verification
REQ-038 Good frame: bytes A5 03 11 22 33 69 with out_ready=1 -> one frame_ok pulse; out_data 11,22,33 on consecutive cycles; out_last only with 33; err_cnt=0.
REQ-039 Bad checksum: A5 02 10 20 31 -> err_chk pulse; no out_valid; err_cnt=1; then A5 01 7F 80 -> frame_ok and out_data=7F with out_last=1.
REQ-040 Length errors: A5 00 -> err_len. A5 11 (MAX_LEN=16) -> err_len. Leading garbage 00 FF A5 01 05 06 -> frame_ok only.
REQ-041 Timeout mid-payload: A5 04 01 02 then timeout rising edge -> err_timeout; state HUNT; a subsequent valid frame is decoded correctly.
REQ-042 Backpressure/overrun: valid 3-byte frame with out_ready=0 for 20 cycles -> out_data=first byte held stable. Extra byte strobe during the stall -> err_overrun. Release out_ready -> all 3 bytes delivered.
REQ-043 Reset/saturation: rst_n low mid-DRAIN -> out_valid=0 immediately. Release with byte_ready=1 -> no strobe. 300 err_len frames -> err_cnt=FF.
